pipe_stage_skid: RTL and testbench



---
 rtl/pipe_stage_skid.sv | 121 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer, flush and
// registered bubble insertion, plus a saturating stall-cycle counter for perf debug.
module pipe_stage_skid #(
    parameter int unsigned       CTRL_W        = 9,
    parameter int unsigned       PAYLOAD_W     = 171,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL   = '0,
    parameter bit                CLEAR_PAYLOAD = 1'b0,
    parameter int unsigned       CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CTRL_W-1:0]    in_ctrl,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic [PAYLOAD_W-1:0] out_payload,
    input  logic                 flush,
    output logic [CNT_W-1:0]     stall_cnt,
    input  logic                 clr_cnt
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e               state_q, state_d;
    logic                 out_valid_q, in_ready_q;
    logic [CTRL_W-1:0]    main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [PAYLOAD_W-1:0] main_payload_q, main_payload_d, skid_payload_q, skid_payload_d;
    logic [CNT_W-1:0]     stall_cnt_q;
    logic                 acc, pop;

    assign acc = in_valid & in_ready_q;
    assign pop = out_valid_q & out_ready;

    always_comb begin
        state_d        = state_q;
        main_ctrl_d    = main_ctrl_q;
        main_payload_d = main_payload_q;
        skid_ctrl_d    = skid_ctrl_q;
        skid_payload_d = skid_payload_q;
        if (flush) begin
            state_d     = StEmpty;
            main_ctrl_d = BUBBLE_CTRL;
            if (CLEAR_PAYLOAD) main_payload_d = '0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (acc) begin
                        state_d        = StOne;
                        main_ctrl_d    = in_ctrl;
                        main_payload_d = in_payload;
                    end
                end
                StOne: begin
                    if (acc && pop) begin
                        main_ctrl_d    = in_ctrl;
                        main_payload_d = in_payload;
                    end else if (acc) begin
                        state_d        = StTwo;
                        skid_ctrl_d    = in_ctrl;
                        skid_payload_d = in_payload;
                    end else if (pop) begin
                        state_d     = StEmpty;
                        main_ctrl_d = BUBBLE_CTRL;
                        if (CLEAR_PAYLOAD) main_payload_d = '0;
                    end
                end
                StTwo: begin
                    // in_ready is low here, so only the skid entry can advance
                    if (pop) begin
                        state_d        = StOne;
                        main_ctrl_d    = skid_ctrl_q;
                        main_payload_d = skid_payload_q;
                    end
                end
                default: begin
                    state_d     = StEmpty;
                    main_ctrl_d = BUBBLE_CTRL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StEmpty;
            out_valid_q    <= 1'b0;
            in_ready_q     <= 1'b1;
            main_ctrl_q    <= BUBBLE_CTRL;
            main_payload_q <= '0;
            skid_ctrl_q    <= '0;
            skid_payload_q <= '0;
        end else begin
            state_q        <= state_d;
            out_valid_q    <= (state_d != StEmpty);
            in_ready_q     <= (state_d != StTwo);
            main_ctrl_q    <= main_ctrl_d;
            main_payload_q <= main_payload_d;
            skid_ctrl_q    <= skid_ctrl_d;
            skid_payload_q <= skid_payload_d;
        end
    end

    // Clear wins over a same-cycle stall; count sticks at all-ones
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            stall_cnt_q <= '0;
        end else if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_ctrl    = main_ctrl_q;
    assign out_payload = main_payload_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench: vector table on the default-parameter stage, hand-written sequences on a
// second instance with a non-zero bubble, payload clearing and a 4-bit stall counter.
module tb_pipe_stage_skid;

    localparam int PW = 171;

    typedef struct {
        logic        rst, iv;
        logic [8:0]  ic;
        logic [31:0] ip;
        logic        ordy, fl, clr;
        logic        ev;
        logic [8:0]  ec;
        logic [31:0] ep;
        logic        eir;
        logic [15:0] es;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, in_valid, in_ready, out_valid, out_ready, flush, clr_cnt;
    logic [8:0]    in_ctrl, out_ctrl;
    logic [PW-1:0] in_payload, out_payload;
    logic [15:0]   stall_cnt;

    logic        b_rst, b_iv, b_ir, b_ov, b_or, b_fl, b_clr;
    logic [8:0]  b_ic, b_oc;
    logic [15:0] b_ip, b_op;
    logic [3:0]  b_sc;

    int checks = 0;
    int failures = 0;
    vec_t tbl[$];

    pipe_stage_skid dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_payload(in_payload), .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_payload(out_payload), .flush(flush),
        .stall_cnt(stall_cnt), .clr_cnt(clr_cnt)
    );

    pipe_stage_skid #(
        .CTRL_W(9), .PAYLOAD_W(16), .BUBBLE_CTRL(9'h1FF), .CLEAR_PAYLOAD(1'b1), .CNT_W(4)
    ) dut_b (
        .clk(clk), .rst(b_rst), .in_valid(b_iv), .in_ready(b_ir), .in_ctrl(b_ic),
        .in_payload(b_ip), .out_valid(b_ov), .out_ready(b_or), .out_ctrl(b_oc),
        .out_payload(b_op), .flush(b_fl), .stall_cnt(b_sc), .clr_cnt(b_clr)
    );

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mk(logic r, logic iv, logic [8:0] ic, logic [31:0] ip,
                                logic o, logic fl, logic cl, logic ev, logic [8:0] ec,
                                logic [31:0] ep, logic eir, logic [15:0] es);
        vec_t v;
        v.rst = r; v.iv = iv; v.ic = ic; v.ip = ip; v.ordy = o; v.fl = fl; v.clr = cl;
        v.ev = ev; v.ec = ec; v.ep = ep; v.eir = eir; v.es = es;
        return v;
    endfunction

    initial begin
        // Fields: rst iv ic ip ordy flush clr | exp: valid ctrl payload in_ready stall_cnt
        tbl.push_back(mk(1, 1, 9'h63, 99, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 9'h63, 99, 0, 0, 0, 0, 0, 0, 1, 0));
        for (int k = 1; k <= 8; k++)
            tbl.push_back(mk(0, 1, 9'(k), 32'(k), 1, 0, 0, 1, 9'(k), 32'(k), 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 8, 1, 0));
        // Skid fill and drain
        tbl.push_back(mk(0, 1, 9'h0A, 'hA, 0, 0, 0, 1, 9'h0A, 'hA, 1, 0));
        tbl.push_back(mk(0, 1, 9'h0B, 'hB, 0, 0, 0, 1, 9'h0A, 'hA, 0, 1));
        tbl.push_back(mk(0, 1, 9'h77, 'h77, 0, 0, 0, 1, 9'h0A, 'hA, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 9'h0B, 'hB, 1, 2));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 'hB, 1, 2));
        // Flush with TWO full and a same-cycle input, then flush of an acceptable input
        tbl.push_back(mk(0, 1, 9'h11, 'h11, 0, 0, 0, 1, 9'h11, 'h11, 1, 2));
        tbl.push_back(mk(0, 1, 9'h12, 'h12, 0, 0, 0, 1, 9'h11, 'h11, 0, 3));
        tbl.push_back(mk(0, 1, 9'h13, 'h13, 0, 1, 0, 0, 0, 'h11, 1, 4));
        tbl.push_back(mk(0, 1, 9'h21, 'h21, 0, 0, 0, 1, 9'h21, 'h21, 1, 4));
        tbl.push_back(mk(0, 1, 9'h22, 'h22, 0, 1, 0, 0, 0, 'h21, 1, 5));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 'h21, 1, 5));
        // Counter clear during a stall
        tbl.push_back(mk(0, 1, 9'h31, 'h31, 0, 0, 0, 1, 9'h31, 'h31, 1, 5));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 9'h31, 'h31, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 9'h31, 'h31, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 'h31, 1, 1));
        // Reset (with flush) while TWO is full
        tbl.push_back(mk(0, 1, 9'h41, 'h41, 0, 0, 0, 1, 9'h41, 'h41, 1, 1));
        tbl.push_back(mk(0, 1, 9'h42, 'h42, 0, 0, 0, 1, 9'h41, 'h41, 0, 2));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));

        b_rst = 1; b_iv = 0; b_ic = '0; b_ip = '0; b_or = 0; b_fl = 0; b_clr = 0;

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; in_valid = tbl[i].iv; in_ctrl = tbl[i].ic;
            in_payload = PW'(tbl[i].ip); out_ready = tbl[i].ordy; flush = tbl[i].fl;
            clr_cnt = tbl[i].clr;
            tick();
            chk($sformatf("v%0d out_valid", i), 192'(out_valid), 192'(tbl[i].ev));
            chk($sformatf("v%0d out_ctrl", i), 192'(out_ctrl), 192'(tbl[i].ec));
            chk($sformatf("v%0d out_payload", i), 192'(out_payload), 192'(tbl[i].ep));
            chk($sformatf("v%0d in_ready", i), 192'(in_ready), 192'(tbl[i].eir));
            chk($sformatf("v%0d stall_cnt", i), 192'(stall_cnt), 192'(tbl[i].es));
        end

        // Second instance: bubble 1FF, cleared payload, 4-bit counter
        tick();
        chk("b reset ctrl", 192'(b_oc), 192'(9'h1FF));
        chk("b reset payload", 192'(b_op), 192'(0));
        chk("b reset valid", 192'(b_ov), 192'(0));
        b_rst = 0; b_iv = 1; b_ic = 9'h005; b_ip = 16'hABCD;
        tick();
        b_iv = 0;
        chk("b load ctrl", 192'(b_oc), 192'(9'h005));
        chk("b load payload", 192'(b_op), 192'(16'hABCD));
        repeat (20) tick();
        chk("b stall saturate", 192'(b_sc), 192'(15));
        chk("b stall valid", 192'(b_ov), 192'(1));
        b_clr = 1;
        tick();
        b_clr = 0;
        chk("b clr during stall", 192'(b_sc), 192'(0));
        tick();
        chk("b stall after clr", 192'(b_sc), 192'(1));
        b_or = 1;
        tick();
        chk("b drain valid", 192'(b_ov), 192'(0));
        chk("b drain ctrl", 192'(b_oc), 192'(9'h1FF));
        chk("b drain payload", 192'(b_op), 192'(0));
        chk("b drain stall", 192'(b_sc), 192'(1));
        b_or = 0; b_iv = 1; b_ic = 9'h003; b_ip = 16'h1234;
        tick();
        chk("b reload payload", 192'(b_op), 192'(16'h1234));
        b_ic = 9'h007; b_ip = 16'h5678; b_fl = 1;
        tick();
        b_fl = 0; b_iv = 0;
        chk("b flush valid", 192'(b_ov), 192'(0));
        chk("b flush ctrl", 192'(b_oc), 192'(9'h1FF));
        chk("b flush payload", 192'(b_op), 192'(0));
        chk("b flush in_ready", 192'(b_ir), 192'(1));
        chk("b flush stall", 192'(b_sc), 192'(2));
        tick();
        chk("b flushed input dropped", 192'(b_ov), 192'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
